// File: rtl/chaser_pkg.sv
// Shared definitions for the button decoder, chaser and mode-control blocks.
// Holds the button FSM state encodings and a counter-width helper.
package chaser_pkg;

    localparam logic [2:0] BTN_ST_IDLE     = 3'd0;
    localparam logic [2:0] BTN_ST_PRESS_DB = 3'd1;
    localparam logic [2:0] BTN_ST_HELD     = 3'd2;
    localparam logic [2:0] BTN_ST_LONG     = 3'd3;
    localparam logic [2:0] BTN_ST_REL_DB   = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = BTN_ST_IDLE,
        StPressDb = BTN_ST_PRESS_DB,
        StHeld    = BTN_ST_HELD,
        StLong    = BTN_ST_LONG,
        StRelDb   = BTN_ST_REL_DB
    } btn_state_e;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_decoder.sv
// Debounced pushbutton decoder: registered level plus one-cycle short/long press pulses.
// Press and release must each stay stable for DEBOUNCE_CYCLES synchronized cycles.
module button_decoder
    import chaser_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 60000,
    parameter int unsigned LONG_CYCLES     = 3000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_level,
    output logic short_press,
    output logic long_press
);

    localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = cnt_width(LONG_CYCLES);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

    btn_state_e       state;
    logic [DbW-1:0]   db_cnt;
    logic [HoldW-1:0] hold_cnt;
    logic             long_seen;
    logic             p;

    // The pin is inverted ahead of the synchronizer so the zero reset value of
    // the flops reads as "not pressed"; a single inverter adds no glitch risk.
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (~btn_n),
        .q     (p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_seen   <= 1'b0;
            btn_level   <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            short_press <= 1'b0;
            long_press  <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (p) begin
                        state  <= StPressDb;
                        db_cnt <= '0;
                    end
                end

                StPressDb: begin
                    if (!p) begin
                        state     <= StIdle;
                        long_seen <= 1'b0;
                    end else if (db_cnt == DbLast) begin
                        state     <= StHeld;
                        hold_cnt  <= '0;
                        btn_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DbW'(1);
                    end
                end

                StHeld: begin
                    if (!p) begin
                        state  <= StRelDb;
                        db_cnt <= '0;
                    end else if (hold_cnt == HoldLast) begin
                        state      <= StLong;
                        long_press <= 1'b1;
                        long_seen  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HoldW'(1);
                    end
                end

                StLong: begin
                    if (!p) begin
                        state  <= StRelDb;
                        db_cnt <= '0;
                    end
                end

                // A bounce back to pressed resumes holding; hold_cnt was left untouched.
                StRelDb: begin
                    if (p) begin
                        state <= long_seen ? StLong : StHeld;
                    end else if (db_cnt == DbLast) begin
                        state       <= StIdle;
                        btn_level   <= 1'b0;
                        short_press <= ~long_seen;
                        long_seen   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DbW'(1);
                    end
                end

                default: begin
                    state     <= StIdle;
                    btn_level <= 1'b0;
                    long_seen <= 1'b0;
                end
            endcase
        end
    end

endmodule
